// File: rtl/sd_block_server.sv
// sd_block_server: responder end of the MiST SD block interface.
// Serves one 512-byte block per request out of a byte-wide backing image
// memory, standing in for the IO controller. Requests whose block address
// is at or past the end of the image complete with zero data (reads) or
// discarded data (writes) and an err pulse as sd_ack falls.
//
// Handshakes:
//   sd_rd/sd_wr are request levels. A level seen in IDLE is accepted; levels
//   seen in any other state are ignored. The initiator holds its level until
//   it sees sd_ack, and may raise the next one in the cycle after sd_ack falls.
//   mem_req is held with a stable mem_addr/mem_we/mem_wdata until the clock
//   edge at which mem_ready=1 is sampled; mem_rdata is taken in that cycle.
//   A reset drops mem_req without waiting for mem_ready.
//
// dbg_state exposes the FSM: 0 IDLE, 1 DELAY, 2 RD_REQ, 3 RD_PUT,
// 4 WR_ADDR, 5 WR_LAT, 6 WR_REQ, 7 FINISH.

module sd_block_server #(
    parameter int LBA_BITS  = 14,
    parameter int ACK_DELAY = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         sd_lba,
    input  logic                sd_rd,
    input  logic                sd_wr,
    output logic                sd_ack,
    output logic [8:0]          sd_buff_addr,
    output logic [7:0]          sd_buff_dout,
    output logic                sd_buff_wr,
    input  logic [7:0]          sd_buff_din,
    input  logic [31:0]         img_blocks,
    output logic [LBA_BITS+8:0] mem_addr,
    output logic                mem_req,
    output logic                mem_we,
    output logic [7:0]          mem_wdata,
    input  logic [7:0]          mem_rdata,
    input  logic                mem_ready,
    output logic                busy,
    output logic                err,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DELAY   = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_PUT  = 3'd3,
        S_WR_ADDR = 3'd4,
        S_WR_LAT  = 3'd5,
        S_WR_REQ  = 3'd6,
        S_FINISH  = 3'd7
    } state_t;

    // Delay counter only needs to hold ACK_DELAY-1.
    localparam int DW = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

    state_t                r_state;
    logic [DW-1:0]         r_delay;
    logic [9:0]            r_byte;
    logic [LBA_BITS-1:0]   r_lba;
    logic                  r_is_wr;
    logic                  r_oor;

    logic                  r_ack;
    logic [8:0]            r_buff_addr;
    logic [7:0]            r_buff_dout;
    logic                  r_buff_wr;
    logic [LBA_BITS+8:0]   r_mem_addr;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [7:0]            r_mem_wdata;
    logic                  r_busy;
    logic                  r_err;

    logic [9:0]            w_byte_next;
    logic                  w_last;
    logic                  w_oor;
    logic                  w_req;

    // Byte sequencing and request decode helpers.
    assign w_byte_next = r_byte + 10'd1;
    assign w_last      = (r_byte == 10'd511);
    assign w_oor       = (sd_lba >= img_blocks);
    assign w_req       = sd_rd | sd_wr;

    // Outputs come straight from registers.
    assign sd_ack       = r_ack;
    assign sd_buff_addr = r_buff_addr;
    assign sd_buff_dout = r_buff_dout;
    assign sd_buff_wr   = r_buff_wr;
    assign mem_addr     = r_mem_addr;
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_wdata    = r_mem_wdata;
    assign busy         = r_busy;
    assign err          = r_err;
    assign dbg_state    = r_state;

    // Block FSM: accept, controller latency, per-byte read/write loops, finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_delay     <= '0;
            r_byte      <= '0;
            r_lba       <= '0;
            r_is_wr     <= 1'b0;
            r_oor       <= 1'b0;
            r_ack       <= 1'b0;
            r_buff_addr <= '0;
            r_buff_dout <= '0;
            r_buff_wr   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Read wins when both levels are up; the address is
                    // only looked at here.
                    if (w_req) begin
                        r_lba   <= sd_lba[LBA_BITS-1:0];
                        r_is_wr <= ~sd_rd;
                        r_oor   <= w_oor;
                        r_busy  <= 1'b1;
                        r_delay <= DW'(ACK_DELAY - 1);
                        r_state <= S_DELAY;
                    end
                end

                S_DELAY: begin
                    if (r_delay == '0) begin
                        r_ack  <= 1'b1;
                        r_byte <= '0;
                        if (r_is_wr) begin
                            // Present byte 0 to the initiator buffer now so
                            // its read data is ready two clocks later.
                            r_buff_addr <= 9'd0;
                            r_state     <= S_WR_ADDR;
                        end else begin
                            if (!r_oor) begin
                                r_mem_req  <= 1'b1;
                                r_mem_we   <= 1'b0;
                                r_mem_addr <= {r_lba, 9'd0};
                            end
                            r_state <= S_RD_REQ;
                        end
                    end else begin
                        r_delay <= r_delay - 1'b1;
                    end
                end

                S_RD_REQ: begin
                    // Out-of-range blocks never touch memory and read as zero.
                    if (r_oor || mem_ready) begin
                        r_mem_req   <= 1'b0;
                        r_buff_addr <= r_byte[8:0];
                        r_buff_dout <= r_oor ? 8'h00 : mem_rdata;
                        r_buff_wr   <= 1'b1;
                        r_state     <= S_RD_PUT;
                    end
                end

                S_RD_PUT: begin
                    r_buff_wr <= 1'b0;
                    if (w_last) begin
                        r_ack   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= r_oor;
                        r_state <= S_FINISH;
                    end else begin
                        r_byte <= w_byte_next;
                        if (!r_oor) begin
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {r_lba, w_byte_next[8:0]};
                        end
                        r_state <= S_RD_REQ;
                    end
                end

                S_WR_ADDR: begin
                    // sd_buff_addr already holds this byte's index.
                    r_state <= S_WR_LAT;
                end

                S_WR_LAT: begin
                    // Initiator buffer is registered: din for the current
                    // address is valid at the end of this clock.
                    if (!r_oor) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= sd_buff_din;
                        r_mem_addr  <= {r_lba, r_byte[8:0]};
                    end
                    r_state <= S_WR_REQ;
                end

                S_WR_REQ: begin
                    if (r_oor || mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (w_last) begin
                            r_ack   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_err   <= r_oor;
                            r_state <= S_FINISH;
                        end else begin
                            r_byte      <= w_byte_next;
                            r_buff_addr <= w_byte_next[8:0];
                            r_state     <= S_WR_ADDR;
                        end
                    end
                end

                S_FINISH: begin
                    // One clock with sd_ack low before a new level is taken.
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_server.sv
// Bench for sd_block_server: byte memory responder with random latency,
// registered-buffer initiator, negedge monitor and a block-level model.

module tb_sd_block_server;

    localparam int LB   = 6;
    localparam int AD   = 4;
    localparam int MEMN = 1 << (LB + 9);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   sd_lba = '0;
    logic          sd_rd = 1'b0;
    logic          sd_wr = 1'b0;
    logic          sd_ack;
    logic [8:0]    sd_buff_addr;
    logic [7:0]    sd_buff_dout;
    logic          sd_buff_wr;
    logic [7:0]    sd_buff_din = '0;
    logic [31:0]   img_blocks = 32'd64;
    logic [LB+8:0] mem_addr;
    logic          mem_req;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          busy;
    logic          err;
    logic [2:0]    dbg_state;

    int checks = 0;
    int failures = 0;

    // Memory image, model image, initiator write buffer.
    logic [7:0] mem     [0:MEMN-1];
    logic [7:0] ref_mem [0:MEMN-1];
    logic [7:0] wbuf    [0:511];

    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];

    int lat_max = 1;
    int lat_cur = 1;
    int mem_cnt = 0;

    // Monitor counters
    int cyc = 0;
    int accept_cnt = 0, ack_rise_cnt = 0, err_cnt = 0, req_cnt = 0;
    int busy_rise_cyc = 0, ack_rise_cyc = 0, ack_fall_cyc = 0, err_cyc = 0, last_stb_cyc = 0;
    int wr_noack = 0, busy_bad = 0, req_drop = 0, err_wide = 0;
    logic p_busy = 0, p_ack = 0, p_err = 0, p_req = 0, p_rdy = 0;

    sd_block_server #(.LBA_BITS(LB), .ACK_DELAY(AD)) dut (
        .clk(clk), .reset(reset),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .img_blocks(img_blocks),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Backing memory: completes each request after lat_cur clocks.
    always @(posedge clk) begin
        if (mem_ready) begin
            mem_ready <= 1'b0;
            mem_cnt   <= 0;
        end else if (mem_req) begin
            if (mem_cnt + 1 >= lat_cur) begin
                mem_ready <= 1'b1;
                if (mem_we) mem[mem_addr] <= mem_wdata;
                else        mem_rdata <= mem[mem_addr];
                lat_cur <= $urandom_range(lat_max, 1);
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    // Initiator track buffer with registered read port.
    always @(posedge clk) sd_buff_din <= wbuf[sd_buff_addr];

    // Monitor on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (sd_buff_wr) begin
                obs_q.push_back({sd_buff_addr, sd_buff_dout});
                last_stb_cyc = cyc;
                if (!sd_ack) wr_noack++;
            end
            if (busy && !p_busy) begin accept_cnt++; busy_rise_cyc = cyc; end
            if (sd_ack && !p_ack) begin ack_rise_cnt++; ack_rise_cyc = cyc; end
            if (!sd_ack && p_ack) ack_fall_cyc = cyc;
            if (err) begin err_cnt++; err_cyc = cyc; if (p_err) err_wide++; end
            if (mem_req && !p_req) req_cnt++;
            if (p_req && !p_rdy && !mem_req) req_drop++;
            if (sd_ack && !busy) busy_bad++;
        end
        p_busy = busy; p_ack = sd_ack; p_err = err; p_req = mem_req; p_rdy = mem_ready;
    end

    // ---------------- model ----------------
    function automatic logic [LB+8:0] maddr(input int lba, input int i);
        maddr = {LB'(lba), 9'(i)};
    endfunction

    task automatic model_read(input int lba);
        for (int i = 0; i < 512; i++)
            exp_q.push_back({9'(i), (32'(lba) >= img_blocks) ? 8'h00 : ref_mem[maddr(lba, i)]});
    endtask

    task automatic model_write(input int lba);
        if (32'(lba) < img_blocks)
            for (int i = 0; i < 512; i++) ref_mem[maddr(lba, i)] = wbuf[i];
    endtask

    // ---------------- drivers ----------------
    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic run_block(input bit is_wr, input int lba, output bit tmo);
        int n;
        tmo    = 1'b0;
        sd_lba = 32'(lba);
        sd_rd  = !is_wr;
        sd_wr  = is_wr;
        n = 0;
        while (sd_ack !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        if (sd_ack !== 1'b1) tmo = 1'b1;
        n = 0;
        while (sd_ack === 1'b1 && n < 20000) begin @(negedge clk); n++; end
        if (sd_ack === 1'b1) tmo = 1'b1;
    endtask

    task automatic fill_wbuf_random();
        for (int i = 0; i < 512; i++) wbuf[i] = 8'($urandom);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({sd_ack, sd_buff_wr, mem_req, mem_we, busy, err} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b want 000000", {sd_ack, sd_buff_wr, mem_req, mem_we, busy, err});
        end
        checks++;
        if (sd_buff_addr !== 9'd0 || sd_buff_dout !== 8'd0) begin
            failures++; $display("FAIL reset_buff: got addr=%0d dout=%02h want 0 0", sd_buff_addr, sd_buff_dout);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== 8'd0) begin
            failures++; $display("FAIL reset_mem: got addr=%0h wdata=%02h want 0 0", mem_addr, mem_wdata);
        end
        checks++;
        if (dbg_state !== 3'd0) begin
            failures++; $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        reset = 1'b0;
        settle(2);
        checks++;
        if (busy !== 1'b0 || sd_ack !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: got busy=%b ack=%b want 0 0", busy, sd_ack);
        end
    endtask

    task automatic test_read_basic();
        bit tmo;
        logic [16:0] e, o;
        int e0;
        lat_max = 1;
        obs_q.delete();
        e0 = err_cnt;
        run_block(1'b0, 5, tmo);
        settle(3);
        checks++;
        if (tmo) begin failures++; $display("FAIL rd5_timeout: got timeout want completion"); end
        model_read(5);
        checks++;
        if (obs_q.size() != 512) begin failures++; $display("FAIL rd5_count: got %0d want 512", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL rd5_data: got %0d/%02h want %0d/%02h", o[16:8], o[7:0], e[16:8], e[7:0]); end
        end
        exp_q.delete();
        checks++;
        if (ack_rise_cyc - busy_rise_cyc != AD) begin
            failures++; $display("FAIL rd5_ack_delay: got %0d want %0d", ack_rise_cyc - busy_rise_cyc, AD);
        end
        checks++;
        if (ack_fall_cyc != last_stb_cyc + 1) begin
            failures++; $display("FAIL rd5_ack_fall: got cyc %0d want %0d", ack_fall_cyc, last_stb_cyc + 1);
        end
        checks++;
        if (err_cnt != e0) begin failures++; $display("FAIL rd5_err: got %0d pulses want 0", err_cnt - e0); end
        checks++;
        if (busy_bad != 0 || wr_noack != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL rd5_busy: got busy_bad=%0d wr_noack=%0d busy=%b want 0 0 0", busy_bad, wr_noack, busy);
        end
    endtask

    task automatic test_write_basic();
        bit tmo;
        for (int i = 0; i < 512; i++) wbuf[i] = ~8'(i);
        obs_q.delete();
        run_block(1'b1, 3, tmo);
        settle(3);
        model_write(3);
        checks++;
        if (tmo) begin failures++; $display("FAIL wr3_timeout: got timeout want completion"); end
        for (int i = 0; i < 512; i++) begin
            checks++;
            if (mem[maddr(3, i)] !== ref_mem[maddr(3, i)]) begin
                failures++; $display("FAIL wr3_mem[%0d]: got %02h want %02h", i, mem[maddr(3, i)], ref_mem[maddr(3, i)]);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL wr3_strobes: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit tmo;
        int nt, a0, r0;
        logic [16:0] e, o;
        lat_max = 1;
        obs_q.delete();
        a0 = accept_cnt; r0 = ack_rise_cnt; nt = 0;
        for (int b = 26; b <= 38; b++) begin
            run_block(1'b0, b, tmo);
            if (tmo) nt++;
        end
        settle(3);
        checks++;
        if (nt != 0) begin failures++; $display("FAIL b2b_timeout: got %0d want 0", nt); end
        checks++;
        if (accept_cnt - a0 != 13) begin failures++; $display("FAIL b2b_accepts: got %0d want 13", accept_cnt - a0); end
        checks++;
        if (ack_rise_cnt - r0 != 13) begin failures++; $display("FAIL b2b_acks: got %0d want 13", ack_rise_cnt - r0); end
        for (int b = 26; b <= 38; b++) model_read(b);
        checks++;
        if (obs_q.size() != 13 * 512) begin failures++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), 13 * 512); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL b2b_data: got %0d/%02h want %0d/%02h", o[16:8], o[7:0], e[16:8], e[7:0]); end
        end
        exp_q.delete();
    endtask

    task automatic test_out_of_range();
        bit tmo;
        int e0, q0;
        logic [16:0] e, o;
        img_blocks = 32'd10;
        lat_max = 1;
        // Last in-range block: real data, no err.
        obs_q.delete(); e0 = err_cnt;
        run_block(1'b0, 9, tmo);
        settle(3);
        model_read(9);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL rd9_data: got %0d/%02h want %0d/%02h", o[16:8], o[7:0], e[16:8], e[7:0]); end
        end
        exp_q.delete();
        checks++;
        if (tmo || err_cnt != e0) begin failures++; $display("FAIL rd9_err: got tmo=%0d err=%0d want 0 0", tmo, err_cnt - e0); end
        // First out-of-range block, read.
        obs_q.delete(); e0 = err_cnt; q0 = req_cnt;
        run_block(1'b0, 10, tmo);
        settle(3);
        model_read(10);
        checks++;
        if (obs_q.size() != 512 || tmo) begin failures++; $display("FAIL oor_rd_count: got %0d tmo=%0d want 512 0", obs_q.size(), tmo); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL oor_rd_data: got %0d/%02h want %0d/%02h", o[16:8], o[7:0], e[16:8], e[7:0]); end
        end
        exp_q.delete();
        checks++;
        if (req_cnt != q0) begin failures++; $display("FAIL oor_rd_memreq: got %0d want 0", req_cnt - q0); end
        checks++;
        if (err_cnt - e0 != 1 || err_cyc != ack_fall_cyc) begin
            failures++; $display("FAIL oor_rd_err: got %0d pulses at cyc %0d want 1 at %0d", err_cnt - e0, err_cyc, ack_fall_cyc);
        end
        // Out-of-range write: memory untouched.
        fill_wbuf_random();
        e0 = err_cnt; q0 = req_cnt;
        run_block(1'b1, 10, tmo);
        settle(3);
        model_write(10);
        for (int i = 0; i < 512; i++) begin
            checks++;
            if (mem[maddr(10, i)] !== ref_mem[maddr(10, i)]) begin
                failures++; $display("FAIL oor_wr_mem[%0d]: got %02h want %02h", i, mem[maddr(10, i)], ref_mem[maddr(10, i)]);
            end
        end
        checks++;
        if (req_cnt != q0 || tmo) begin failures++; $display("FAIL oor_wr_memreq: got %0d tmo=%0d want 0 0", req_cnt - q0, tmo); end
        checks++;
        if (err_cnt - e0 != 1 || err_wide != 0) begin
            failures++; $display("FAIL oor_wr_err: got %0d pulses wide=%0d want 1 0", err_cnt - e0, err_wide);
        end
        img_blocks = 32'd64;
    endtask

    task automatic test_random_latency();
        bit tmo1, tmo2;
        int lba;
        logic [16:0] e, o;
        lat_max = 7;
        lba = $urandom_range(63, 40);
        fill_wbuf_random();
        run_block(1'b1, lba, tmo1);
        settle(3);
        model_write(lba);
        for (int i = 0; i < 512; i++) begin
            checks++;
            if (mem[maddr(lba, i)] !== ref_mem[maddr(lba, i)]) begin
                failures++; $display("FAIL rl_wr_mem[%0d]: got %02h want %02h", i, mem[maddr(lba, i)], ref_mem[maddr(lba, i)]);
            end
        end
        obs_q.delete();
        run_block(1'b0, lba, tmo2);
        settle(3);
        model_read(lba);
        checks++;
        if (tmo1 || tmo2 || obs_q.size() != 512) begin
            failures++; $display("FAIL rl_done: got tmo=%0d/%0d count=%0d want 0/0 512", tmo1, tmo2, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL rl_rd_data: got %0d/%02h want %0d/%02h", o[16:8], o[7:0], e[16:8], e[7:0]); end
        end
        exp_q.delete();
        checks++;
        if (req_drop != 0 || wr_noack != 0 || busy_bad != 0) begin
            failures++; $display("FAIL rl_handshake: got drop=%0d noack=%0d busy_bad=%0d want 0 0 0", req_drop, wr_noack, busy_bad);
        end
        lat_max = 1;
    endtask

    task automatic test_reset_mid_write();
        bit tmo;
        int n;
        logic [16:0] e, o;
        lat_max = 1;
        fill_wbuf_random();
        sd_lba = 32'd7;
        sd_wr  = 1'b1;
        n = 0;
        while (sd_ack !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        sd_wr = 1'b0;
        n = 0;
        while (!(sd_ack === 1'b1 && sd_buff_addr === 9'd200) && n < 5000) begin @(negedge clk); n++; end
        checks++;
        if (sd_buff_addr !== 9'd200) begin failures++; $display("FAIL rst_reach200: got addr %0d want 200", sd_buff_addr); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (sd_ack !== 1'b0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL rst_abort: got ack=%b req=%b want 0 0", sd_ack, mem_req);
        end
        checks++;
        if (dbg_state !== 3'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_idle: got state=%0d busy=%b want 0 0", dbg_state, busy);
        end
        reset = 1'b0;
        settle(2);
        for (int i = 0; i < 200; i++) ref_mem[maddr(7, i)] = wbuf[i];
        for (int i = 0; i < 200; i++) begin
            checks++;
            if (mem[maddr(7, i)] !== ref_mem[maddr(7, i)]) begin
                failures++; $display("FAIL rst_partial[%0d]: got %02h want %02h", i, mem[maddr(7, i)], ref_mem[maddr(7, i)]);
            end
        end
        obs_q.delete();
        run_block(1'b0, 20, tmo);
        settle(3);
        model_read(20);
        checks++;
        if (tmo || obs_q.size() != 512) begin failures++; $display("FAIL rst_newrd: got tmo=%0d count=%0d want 0 512", tmo, obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL rst_rd_data: got %0d/%02h want %0d/%02h", o[16:8], o[7:0], e[16:8], e[7:0]); end
        end
        exp_q.delete();
    endtask

    // ---------------- sequence ----------------
    initial begin
        for (int a = 0; a < MEMN; a++) begin
            logic [LB+8:0] av;
            av = (LB + 9)'(a);
            mem[a]     = av[7:0] ^ 8'(av[LB+8:9]);
            ref_mem[a] = av[7:0] ^ 8'(av[LB+8:9]);
        end
        for (int i = 0; i < 512; i++) wbuf[i] = 8'd0;
        test_reset();
        test_read_basic();
        test_write_basic();
        test_back_to_back();
        test_out_of_range();
        test_random_latency();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
